handshake_rr_arbiter: RTL
=========================

// Module: handshake_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one valid/ready sink between N valid/ready sources.
//  It grants one requester, registers its word into a one-entry output slot, and
//  presents the word to the shared sink with the source index.
//  It sits between the producer handshakes and the single consumer datapath.
// PARAMETERS
//  N   4  number of requesters, 2..16
//  DW  4  data width per requester
//  IW  2  index width, $clog2(N)
//  CW  8  width of each grant counter (only with HSARB_STATS_EN)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst_n      in   1      synchronous reset, active-low
//  s_valid    in   N      per-requester valid
//  s_data     in   N*DW   requester i data on s_data[i*DW +: DW]
//  s_ready    out  N      per-requester ready, one-hot or zero
//  m_valid    out  1      output slot holds a word
//  m_data     out  DW     buffered word
//  m_src      out  IW     index of the requester that supplied m_data
//  m_ready    in   1      sink accepts m_data this cycle
//  grant_cnt  out  N*CW   per-requester accepted-word count (HSARB_STATS_EN only)
// BEHAVIOUR
//  - Transfer rule: a word moves when valid & ready are high at the same posedge.
//    Sources hold valid and data stable until the word is accepted.
//  - Reset (rst_n=0 at posedge): m_valid=0, m_data=0, m_src=0, ptr=0, counters=0.
//    s_ready is forced to 0 while rst_n=0. A word buffered when reset is applied is dropped.
//  - FSM EMPTY/FULL, held in m_valid.
//    EMPTY: if |s_valid, then s_ready[g]=1, the word is loaded, and the FSM goes to FULL.
//    FULL with m_ready=0: hold; s_ready=0.
//    FULL with m_ready=1 and |s_valid: reload from a new grant the same cycle; stay FULL.
//    FULL with m_ready=1 and no s_valid: go to EMPTY.
//  - Latency: 1 cycle from source handshake to m_valid. Throughput is 1 word/cycle
//    while the sink keeps m_ready high.
//  - s_ready is combinational from s_valid, ptr, m_valid and m_ready. It is one-hot
//    on the granted index g, and only when (!m_valid | m_ready) & |s_valid.
//  - Round-robin pick: g is the first i with s_valid[i], searching ptr, ptr+1, ...,
//    N-1, 0, ..., wrapping mod N.
//  - ptr update: on each grant, ptr <= (g+1) mod N. With no grant, ptr holds.
//  - g=N-1 wraps ptr to 0. A lone requester is granted on every slot.
//  - m_valid does not depend combinationally on m_ready.
//  - m_data and m_src change only on load.
// CONFIGURATION
//  HSARB_STATS_EN defined:
//  - grant_cnt port present.
//  - Counter i increments on each s_valid[i] & s_ready[i].
//  - Counters saturate at 2^CW-1 and reset to 0.
//  HSARB_STATS_EN undefined:
//  - grant_cnt port and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  - handshake_pkg: FSM encoding constants ST_EMPTY/ST_FULL and default widths.
//  - Sub-module rr_pick:
//    - Inputs: req[N], ptr[IW].
//    - Outputs: gnt_oh[N], gnt_idx[IW], any.
//    - Purely combinational; rotate, priority-encode, rotate back.
//  - Top level holds the FSM, the output slot, ptr and optional counters.
// TESTING
//  - Reset: assert rst_n=0 for 2 cycles with s_valid=4'b1111.
//    Expect m_valid=0, s_ready=0, m_src=0 and ptr=0 after release.
//  - Fairness: s_valid=4'b1111 held, m_ready=1.
//    Expect m_src sequence 0,1,2,3,0,1 on consecutive cycles, one word/cycle.
//  - Backpressure: m_ready=0 for 3 cycles with m_valid=1, m_data=4'h5.
//    Expect the slot held, s_ready=0, then released on m_ready=1.
//  - Sparse wrap: s_valid=4'b1000 granted (ptr->0), then s_valid=4'b1001.
//    Expect grant 0 before 3.
//  - Same-cycle drain/refill: FULL, m_ready=1, s_valid[2]=1 with data 4'hA.
//    Expect next m_data=4'hA and m_src=2, m_valid staying high.
//  - HSARB_STATS_EN with CW=2: grant requester 1 five times.
//    Expect grant_cnt[1] saturated at 3 and all other counters 0.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared types and default widths for the handshake round-robin arbiter.
// The grant counters exist only when HSARB_STATS_EN is defined.
package handshake_pkg;

    // The slot FSM state doubles as m_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam int HSARB_N  = 4;
    localparam int HSARB_DW = 4;
    localparam int HSARB_IW = 2;
    localparam int HSARB_CW = 8;

endpackage

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest set bit,
// then rotate the index back so the search order is ptr, ptr+1, ..., wrapping mod N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic           found;
    logic [IW:0]    sum;

    always_comb begin
        req2  = {req, req};
        rot   = req2[ptr +: N];
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                off   = IW'(i);
                found = 1'b1;
            end
        end
        // Rotate back; N need not be a power of two, so wrap explicitly.
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        gnt_idx = sum[IW-1:0];
        gnt_oh  = '0;
        if (found) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    assign any = |req;

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter feeding one valid/ready sink from N valid/ready sources through
// a one-entry output slot. Optional per-requester grant counters: HSARB_STATS_EN.
module handshake_rr_arbiter
    import handshake_pkg::*;
#(
    parameter int N  = HSARB_N,
    parameter int DW = HSARB_DW,
    parameter int IW = HSARB_IW
`ifdef HSARB_STATS_EN
    ,
    parameter int CW = HSARB_CW
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    s_valid,
    input  logic [N*DW-1:0] s_data,
    output logic [N-1:0]    s_ready,
    output logic            m_valid,
    output logic [DW-1:0]   m_data,
    output logic [IW-1:0]   m_src,
    input  logic            m_ready
`ifdef HSARB_STATS_EN
    ,
    output logic [N*CW-1:0] grant_cnt
`endif
);

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_nxt;
    logic [DW-1:0] data_q;
    logic [IW-1:0] src_q;
    logic [DW-1:0] sel_data;
    logic [N-1:0]  gnt_oh;
    logic [IW-1:0] gnt_idx;
    logic          any;
    logic          grant;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (s_valid),
        .ptr     (ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        state_d  = state_q;
        // The slot can take a word when empty or when it drains this cycle.
        grant    = rst_n & any & ((state_q == ST_EMPTY) | m_ready);
        s_ready  = grant ? gnt_oh : '0;
        sel_data = s_data[gnt_idx*DW +: DW];
        ptr_nxt  = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
        case (state_q)
            ST_EMPTY: if (grant) state_d = ST_FULL;
            ST_FULL:  if (m_ready) state_d = any ? ST_FULL : ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                data_q <= sel_data;
                src_q  <= gnt_idx;
                ptr_q  <= ptr_nxt;
            end
        end
    end

    assign m_valid = (state_q == ST_FULL);
    assign m_data  = data_q;
    assign m_src   = src_q;

`ifdef HSARB_STATS_EN
    logic [N-1:0][CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (s_valid[i] && s_ready[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule
